// File: rtl/uart_rx_frame.sv
// UART receiver: oversampled start/data/parity/stop frame decoder.
// Majority-votes three mid-bit samples and strobes data or an error flag.
module uart_rx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int EW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int BW = $clog2(DATA_WIDTH + 3);

    localparam logic [EW-1:0] SMP0 = EW'(PRESCALE / 2 - 1);
    localparam logic [EW-1:0] SMP1 = EW'(PRESCALE / 2);
    localparam logic [EW-1:0] SMP2 = EW'(PRESCALE / 2 + 1);
    localparam logic [EW-1:0] LAST = EW'(PRESCALE - 1);
    localparam logic [BW-1:0] DLST = BW'(DATA_WIDTH);

    state_t                  state_q;
    logic [EW-1:0]           edge_cnt_q;
    logic [EW-1:0]           edge_cnt_d;
    logic [BW-1:0]           bit_cnt_q;
    logic [BW-1:0]           bit_cnt_d;
    logic                    smp0_q;
    logic                    smp1_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    par_en_q;
    logic                    par_typ_q;
    logic                    par_bad_q;
    logic                    stop_bad_q;
    logic                    done_q;

    logic                    wrap;
    logic                    decide;
    logic                    bit_val;

    // Bit timing and majority vote of the three mid-bit samples
    always_comb begin
        wrap       = (edge_cnt_q == LAST);
        decide     = (edge_cnt_q == SMP2);
        bit_val    = (smp0_q & smp1_q) | (smp0_q & RX_IN) | (smp1_q & RX_IN);
        edge_cnt_d = wrap ? '0 : edge_cnt_q + 1'b1;
        bit_cnt_d  = wrap ? bit_cnt_q + 1'b1 : bit_cnt_q;
    end

    // Frame FSM: counters, sampling, shift register and error capture
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            smp0_q     <= 1'b1;
            smp1_q     <= 1'b1;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (edge_cnt_q == SMP0) smp0_q <= RX_IN;
            if (edge_cnt_q == SMP1) smp1_q <= RX_IN;
            if (state_q != IDLE) begin
                edge_cnt_q <= edge_cnt_d;
                bit_cnt_q  <= bit_cnt_d;
            end
            unique case (state_q)
                IDLE: begin
                    if (!RX_IN) begin
                        state_q    <= START;
                        edge_cnt_q <= EW'(1);
                        bit_cnt_q  <= '0;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        par_bad_q  <= 1'b0;
                    end
                end
                START: begin
                    if (decide && bit_val) begin
                        state_q    <= IDLE;
                        edge_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                    end else if (wrap) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (decide) shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
                    if (wrap && bit_cnt_q == DLST)
                        state_q <= par_en_q ? PARITY : STOP;
                end
                PARITY: begin
                    if (decide)
                        par_bad_q <= ((^shift_q) ^ par_typ_q) != bit_val;
                    if (wrap) state_q <= STOP;
                end
                STOP: begin
                    if (decide) begin
                        state_q    <= IDLE;
                        edge_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        done_q     <= 1'b1;
                        stop_bad_q <= ~bit_val;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    edge_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                end
            endcase
        end
    end

    // Registered strobes one cycle after the stop decision; stop error wins
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
            if (done_q) begin
                if (stop_bad_q) begin
                    Stp_Err <= 1'b1;
                end else if (par_bad_q) begin
                    Par_Err <= 1'b1;
                end else begin
                    Data_Valid <= 1'b1;
                    P_DATA     <= shift_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: driver queues expected strobes,
// a negedge monitor pops and compares kind, data and cycle.
module tb_uart_rx_frame;

    localparam int P = 8;
    localparam logic [2:0] K_DV = 3'b100;
    localparam logic [2:0] K_PE = 3'b010;
    localparam logic [2:0] K_SE = 3'b001;
    localparam logic [2:0] K_NO = 3'b000;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_Err;
    logic       Stp_Err;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         at;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;

    uart_rx_frame #(.DATA_WIDTH(8), .PRESCALE(P)) dut (
        .CLK(CLK),
        .RST(RST),
        .RX_IN(RX_IN),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .P_DATA(P_DATA),
        .Data_Valid(Data_Valid),
        .Par_Err(Par_Err),
        .Stp_Err(Stp_Err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: every strobe cycle must match the head of the scoreboard
    always @(negedge CLK) begin
        logic [2:0] got;
        exp_t       e;
        got = {Data_Valid, Par_Err, Stp_Err};
        if (got != 3'b000) begin
            checks++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: cycle %0d strobes %b data %h",
                         cyc, got, P_DATA);
            end else begin
                e = q.pop_front();
                if (got !== e.kind || P_DATA !== e.data || cyc != e.at) begin
                    fails++;
                    $display("FAIL %s: got strobes %b data %h cycle %0d, want %b %h %0d",
                             e.name, got, P_DATA, cyc, e.kind, e.data, e.at);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, expv);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            RX_IN = 1'b1;
        end
    endtask

    // Drive one frame bit-per-PRESCALE; flips PAR_EN/PAR_TYP mid-frame
    task automatic send(input string nm, input logic [7:0] d,
                        input logic pe, input logic pt, input logic pbit,
                        input logic stopb, input int glitch,
                        input logic [2:0] kind, input logic [7:0] expd);
        int          n;
        logic [10:0] fr;
        exp_t        e;
        n = pe ? 11 : 10;
        fr = '1;
        fr[0] = 1'b0;
        fr[8:1] = d;
        if (pe) begin
            fr[9] = pbit;
            fr[10] = stopb;
        end else begin
            fr[9] = stopb;
        end
        PAR_EN = pe;
        PAR_TYP = pt;
        for (int t = 0; t < n * P; t++) begin
            @(negedge CLK);
            if (t == 0 && kind != K_NO) begin
                e.kind = kind;
                e.data = expd;
                e.at = cyc + 1 + (n - 1) * P + P / 2 + 2;
                e.name = nm;
                q.push_back(e);
            end
            if (t == 3 * P) begin
                PAR_EN = ~pe;
                PAR_TYP = ~pt;
            end
            RX_IN = (t == glitch) ? 1'b0 : fr[t / P];
        end
    endtask

    initial begin
        logic [10:0] fr3;
        int          w;
        repeat (3) @(negedge CLK);
        chk("rst_pdata", P_DATA, 0);
        chk("rst_dv", Data_Valid, 0);
        chk("rst_pe", Par_Err, 0);
        chk("rst_se", Stp_Err, 0);
        RST = 1'b1;
        idle(4);

        send("a5", 8'hA5, 0, 0, 0, 1, -1, K_DV, 8'hA5);
        idle(4);
        send("3c_even", 8'h3C, 1, 0, 0, 1, -1, K_DV, 8'h3C);
        idle(4);
        send("3c_parerr", 8'h3C, 1, 0, 1, 1, -1, K_PE, 8'h3C);
        idle(4);
        send("3d_odd", 8'h3D, 1, 1, 0, 1, -1, K_DV, 8'h3D);
        idle(4);
        send("55_stperr", 8'h55, 0, 0, 0, 0, -1, K_SE, 8'h3D);
        idle(16);
        send("0f", 8'h0F, 0, 0, 0, 1, -1, K_DV, 8'h0F);
        idle(4);

        @(negedge CLK);
        RX_IN = 1'b0;
        @(negedge CLK);
        RX_IN = 1'b0;
        idle(20);
        send("81", 8'h81, 0, 0, 0, 1, -1, K_DV, 8'h81);
        idle(4);
        send("ff_glitch", 8'hFF, 0, 0, 0, 1, 36, K_DV, 8'hFF);
        idle(4);

        send("b2b_12", 8'h12, 0, 0, 0, 1, -1, K_DV, 8'h12);
        send("b2b_34", 8'h34, 0, 0, 0, 1, -1, K_DV, 8'h34);

        fr3 = '1;
        fr3[0] = 1'b0;
        fr3[8:1] = 8'h56;
        for (int t = 0; t < 40; t++) begin
            @(negedge CLK);
            RX_IN = fr3[t / P];
        end
        @(negedge CLK);
        RST = 1'b0;
        RX_IN = 1'b1;
        #1;
        chk("midrst_pdata", P_DATA, 0);
        chk("midrst_dv", Data_Valid, 0);
        chk("midrst_pe", Par_Err, 0);
        chk("midrst_se", Stp_Err, 0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        idle(100);
        chk("post_rst_pdata", P_DATA, 0);

        w = 0;
        while (q.size() != 0 && w < 500) begin
            @(negedge CLK);
            w++;
        end
        chk("scoreboard_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
